// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: FSM state encoding and
// the protocol constants also used by the UART receiver.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OP      = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_PEND    = 3'd5
    } state_t;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT  = 8'hA5;
    localparam logic [7:0]  SPEED_OP_DEFAULT   = 8'h01;
    localparam logic [12:0] UART_SPEED_DEFAULT = 13'h1869;

    // Cycles-per-bit word carried big-endian in the two payload bytes.
    function automatic logic [12:0] speed_word(input logic [4:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload register file: one synchronous write port, one combinational read port.
module uart_cmd_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // NOTE: no reset on the storage array; contents are only meaningful once a
    // frame has written them, and the parser masks the read port otherwise.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_parser.sv
// Frame assembler between the UART receiver and the core: SYNC OP LEN PAYLOAD CHK.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int          MAX_LEN   = 16,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter logic [7:0]  SPEED_OP  = SPEED_OP_DEFAULT
`ifdef UART_CMD_TIMEOUT_EN
    , parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000
`endif
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           byte_valid,
    input  logic [7:0]                     byte_in,
    output logic                           cmd_valid,
    input  logic                           cmd_ready,
    output logic [7:0]                     cmd_op,
    output logic [$clog2(MAX_LEN+1)-1:0]   cmd_len,
    input  logic [$clog2(MAX_LEN)-1:0]     rd_addr,
    output logic [7:0]                     rd_data,
    output logic [12:0]                    speed,
    output logic                           set_speed,
    output logic                           err_chk,
    output logic                           err_len,
    output logic                           err_drop
`ifdef UART_CMD_TIMEOUT_EN
    , output logic                         err_timeout
`endif
);

    localparam int         IDX_W     = $clog2(MAX_LEN);
    localparam int         LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t           state, state_nxt;
    logic             prev_valid;
    logic             accept;
    logic [7:0]       op_q;
    logic [7:0]       chk;
    logic [LEN_W-1:0] len_q;
    logic [IDX_W-1:0] idx;
    logic [4:0]       spd_hi;
    logic [7:0]       spd_lo;
    logic             last_payload;
    logic             chk_ok;
    logic             speed_cmd;
    logic             buf_we;
    logic             timeout_hit;
    logic [7:0]       buf_rdata;

    // A held strobe counts once: only its rising edge is an accept.
    assign accept       = byte_valid & ~prev_valid;
    assign last_payload = (LEN_W'(idx) + LEN_W'(1)) == len_q;
    assign chk_ok       = (byte_in == chk);
    assign speed_cmd    = (op_q == SPEED_OP) && (len_q == LEN_W'(2));
    assign buf_we       = accept && (state == ST_PAYLOAD);

`ifdef UART_CMD_TIMEOUT_EN
    logic [19:0] tmo_cnt;
    logic        frame_active;

    assign frame_active = state inside {ST_OP, ST_LEN, ST_PAYLOAD, ST_CHK};
    assign timeout_hit  = frame_active && !accept && (tmo_cnt == TIMEOUT_CYCLES - 20'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if (accept || !frame_active || timeout_hit) tmo_cnt <= '0;
            else                                        tmo_cnt <= tmo_cnt + 20'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept && byte_in == SYNC_BYTE) state_nxt = ST_OP;
            ST_OP:      if (accept) state_nxt = ST_LEN;
            ST_LEN: begin
                if (accept) begin
                    if (byte_in > MAX_LEN_B)   state_nxt = ST_IDLE;
                    else if (byte_in == 8'h00) state_nxt = ST_CHK;
                    else                       state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: if (accept && last_payload) state_nxt = ST_CHK;
            ST_CHK: begin
                if (accept) begin
                    if (!chk_ok || speed_cmd) state_nxt = ST_IDLE;
                    else                      state_nxt = ST_PEND;
                end
            end
            ST_PEND:    if (cmd_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (timeout_hit) state_nxt = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments; pulses default low each cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            prev_valid <= 1'b0;
            op_q       <= '0;
            chk        <= '0;
            len_q      <= '0;
            idx        <= '0;
            spd_hi     <= '0;
            spd_lo     <= '0;
            speed      <= UART_SPEED_DEFAULT;
            set_speed  <= 1'b0;
            err_chk    <= 1'b0;
            err_len    <= 1'b0;
            err_drop   <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_valid <= byte_valid;
            set_speed  <= 1'b0;
            err_chk    <= 1'b0;
            err_len    <= 1'b0;
            err_drop   <= 1'b0;
            if (accept) begin
                case (state)
                    ST_OP: begin
                        op_q <= byte_in;
                        chk  <= byte_in;
                    end
                    ST_LEN: begin
                        if (byte_in > MAX_LEN_B) begin
                            err_len <= 1'b1;
                        end else begin
                            len_q <= byte_in[LEN_W-1:0];
                            chk   <= chk ^ byte_in;
                            idx   <= '0;
                        end
                    end
                    ST_PAYLOAD: begin
                        chk <= chk ^ byte_in;
                        idx <= idx + IDX_W'(1);
                        if (idx == IDX_W'(0)) spd_hi <= byte_in[4:0];
                        if (idx == IDX_W'(1)) spd_lo <= byte_in;
                    end
                    ST_CHK: begin
                        if (!chk_ok) begin
                            err_chk <= 1'b1;
                        end else if (speed_cmd) begin
                            speed     <= speed_word(spd_hi, spd_lo);
                            set_speed <= 1'b1;
                        end
                    end
                    ST_PEND: err_drop <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    uart_cmd_buf #(.DEPTH(MAX_LEN), .AW(IDX_W)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx),
        .wdata (byte_in),
        .raddr (rd_addr),
        .rdata (buf_rdata)
    );

    assign cmd_valid = (state == ST_PEND);
    assign cmd_op    = op_q;
    assign cmd_len   = len_q;
    assign rd_data   = (state == ST_PEND) ? buf_rdata : 8'h00;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomised bench for uart_cmd_parser against a queue-based frame model.
// Build with UART_CMD_TIMEOUT_EN defined to also exercise the timeout path.
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [4:0]  cmd_len;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [12:0] speed;
    logic        set_speed;
    logic        err_chk;
    logic        err_len;
    logic        err_drop;
`ifdef UART_CMD_TIMEOUT_EN
    logic        err_timeout;
`endif

    always #5 clk = ~clk;

`ifdef UART_CMD_TIMEOUT_EN
    uart_cmd_parser #(.TIMEOUT_CYCLES(20'd100)) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_valid  (byte_valid),
        .byte_in     (byte_in),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .speed       (speed),
        .set_speed   (set_speed),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_drop    (err_drop),
        .err_timeout (err_timeout)
    );
`else
    uart_cmd_parser dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .speed      (speed),
        .set_speed  (set_speed),
        .err_chk    (err_chk),
        .err_len    (err_len),
        .err_drop   (err_drop)
    );
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is the list of bytes seen after SYNC; it is
    // judged once it is long enough to hold OP, LEN, LEN payload bytes and CHK.
    logic [7:0]  frame[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  m_payload[16];
    bit          m_prev, m_in_frame, m_pend;
    logic [7:0]  m_op;
    int          m_len;
    logic [12:0] m_speed;
    bit          e_set_speed, e_err_chk, e_err_len, e_err_drop;
    bit          ready_en, ready_force;
    int          n_set_speed, n_err_chk, n_err_len, n_err_drop;

    task automatic model_reset();
        frame.delete();
        m_prev = 0; m_in_frame = 0; m_pend = 0;
        m_speed = 13'h1869;
        e_set_speed = 0; e_err_chk = 0; e_err_len = 0; e_err_drop = 0;
    endtask

    task automatic model_step(input bit bv, input logic [7:0] b, input bit rdy);
        bit         acc;
        logic [7:0] sum;
        acc = bv && !m_prev;
        m_prev = bv;
        e_set_speed = 0; e_err_chk = 0; e_err_len = 0; e_err_drop = 0;
        if (m_pend) begin
            if (acc) e_err_drop = 1;
            if (rdy) m_pend = 0;
        end else if (acc) begin
            if (!m_in_frame) begin
                if (b == 8'hA5) begin
                    m_in_frame = 1;
                    frame.delete();
                end
            end else begin
                frame.push_back(b);
                if (frame.size() == 2 && frame[1] > 8'd16) begin
                    e_err_len = 1;
                    m_in_frame = 0;
                end else if (frame.size() >= 2 && frame.size() == int'(frame[1]) + 3) begin
                    sum = 8'h00;
                    for (int i = 0; i < frame.size() - 1; i++) sum ^= frame[i];
                    m_in_frame = 0;
                    if (sum != b) begin
                        e_err_chk = 1;
                    end else if (frame[0] == 8'h01 && frame[1] == 8'd2) begin
                        e_set_speed = 1;
                        m_speed = {frame[2][4:0], frame[3]};
                    end else begin
                        m_pend = 1;
                        m_op = frame[0];
                        m_len = int'(frame[1]);
                        for (int i = 0; i < m_len; i++) m_payload[i] = frame[i + 2];
                    end
                end
            end
        end
    endtask

    task automatic compare_outputs();
        check("cmd_valid", 32'(cmd_valid), 32'(m_pend));
        check("set_speed", 32'(set_speed), 32'(e_set_speed));
        check("err_chk", 32'(err_chk), 32'(e_err_chk));
        check("err_len", 32'(err_len), 32'(e_err_len));
        check("err_drop", 32'(err_drop), 32'(e_err_drop));
        check("speed", 32'(speed), 32'(m_speed));
        if (m_pend) begin
            check("cmd_op", 32'(cmd_op), 32'(m_op));
            check("cmd_len", 32'(cmd_len), 32'(m_len));
            if (m_len > 0) begin
                rd_addr = 4'($urandom_range(0, m_len - 1));
                #1;
                check("rd_data", 32'(rd_data), 32'(m_payload[rd_addr]));
            end
        end
        n_set_speed += int'(set_speed);
        n_err_chk   += int'(err_chk);
        n_err_len   += int'(err_len);
        n_err_drop  += int'(err_drop);
    endtask

    task automatic tick(input bit bv, input logic [7:0] b);
        byte_valid = bv;
        byte_in    = bv ? b : 8'($urandom);
        cmd_ready  = ready_force || (ready_en && ($urandom_range(0, 3) == 0));
        model_step(bv, b, cmd_ready);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        repeat (hold) tick(1'b1, b);
        repeat ($urandom_range(1, 3)) tick(1'b0, 8'h00);
    endtask

    // hold == 0 picks a random strobe length per byte.
    task automatic send_queue(input int hold);
        logic [7:0] b;
        while (tx_q.size() > 0) begin
            b = tx_q.pop_front();
            send_byte(b, (hold != 0) ? hold : int'($urandom_range(1, 3)));
        end
    endtask

    task automatic build_frame(input logic [7:0] op, input int len, input bit bad_chk);
        logic [7:0] c, b;
        tx_q.push_back(8'hA5);
        tx_q.push_back(op);
        tx_q.push_back(8'(len));
        c = op ^ 8'(len);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            tx_q.push_back(b);
            c ^= b;
        end
        if (bad_chk) c ^= 8'($urandom_range(1, 255));
        tx_q.push_back(c);
    endtask

    task automatic push_bytes(input logic [47:0] bytes, input int n);
        for (int i = n - 1; i >= 0; i--) tx_q.push_back(bytes[i*8 +: 8]);
    endtask

    task automatic clear_counts();
        n_set_speed = 0; n_err_chk = 0; n_err_len = 0; n_err_drop = 0;
    endtask

    task automatic release_cmd();
        ready_force = 1;
        tick(1'b0, 8'h00);
        ready_force = 0;
        tick(1'b0, 8'h00);
        check("released", 32'(cmd_valid), 32'(0));
    endtask

    task automatic do_reset();
        byte_valid = 0;
        cmd_ready  = 0;
        reset      = 1;
        #2;
        check("rst_cmd_valid", 32'(cmd_valid), 32'(0));
        check("rst_speed", 32'(speed), 32'(13'h1869));
        check("rst_set_speed", 32'(set_speed), 32'(0));
        check("rst_errs", 32'({err_chk, err_len, err_drop}), 32'(0));
        check("rst_cmd_op", 32'(cmd_op), 32'(0));
        check("rst_cmd_len", 32'(cmd_len), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        rd_addr = 0; byte_in = 0; ready_en = 0; ready_force = 0;
        clear_counts();
        do_reset();

        // Plain command, held pending until released.
        push_bytes(48'hA5_10_02_11_22_21, 6);
        send_queue(1);
        check("dir_cmd_op", 32'(cmd_op), 32'(8'h10));
        check("dir_cmd_len", 32'(cmd_len), 32'(2));
        rd_addr = 4'd0; #1;
        check("dir_rd0", 32'(rd_data), 32'(8'h11));
        rd_addr = 4'd1; #1;
        check("dir_rd1", 32'(rd_data), 32'(8'h22));
        release_cmd();

        // Local speed command, then a normal frame.
        clear_counts();
        push_bytes(48'hA5_01_02_01_45_47, 6);
        send_queue(1);
        check("dir_speed", 32'(speed), 32'(13'h0145));
        check("dir_set_speed_cnt", 32'(n_set_speed), 32'(1));
        push_bytes(48'h00_A5_20_01_7E_5F, 5);
        send_queue(2);
        check("dir_after_speed_op", 32'(cmd_op), 32'(8'h20));
        release_cmd();

        // Bad checksum followed by an empty-payload command.
        clear_counts();
        push_bytes(48'hA5_10_02_11_22_20, 6);
        push_bytes(48'h0000_A5_30_00_30, 4);
        send_queue(0);
        check("dir_chk_cnt", 32'(n_err_chk), 32'(1));
        check("dir_len0_op", 32'(cmd_op), 32'(8'h30));
        check("dir_len0_len", 32'(cmd_len), 32'(0));
        release_cmd();

        // Junk before SYNC, oversize LEN, with a 5-cycle strobe.
        clear_counts();
        push_bytes(48'h0000_3C_5A_A5_10, 4);
        tx_q.push_back(8'h11);
        send_queue(5);
        check("dir_len_cnt", 32'(n_err_len), 32'(1));
        check("dir_len_other_errs", 32'(n_err_chk + n_err_drop), 32'(0));

        // Drops while pending, then SYNC in the release cycle.
        clear_counts();
        push_bytes(48'h0000_A5_40_01_99, 4);
        tx_q.push_back(8'hD8);
        push_bytes(48'h000000_A5_12_34, 3);
        send_queue(1);
        check("dir_drop_cnt", 32'(n_err_drop), 32'(3));
        check("dir_drop_op", 32'(cmd_op), 32'(8'h40));
        rd_addr = 4'd0; #1;
        check("dir_drop_rd0", 32'(rd_data), 32'(8'h99));
        ready_force = 1;
        tick(1'b1, 8'hA5);
        ready_force = 0;
        check("dir_release_drop", 32'(err_drop), 32'(1));
        push_bytes(48'h0000_30_00_30_00, 3);
        send_queue(1);
        check("dir_no_frame", 32'(cmd_valid), 32'(0));

        // Reset mid-payload.
        push_bytes(48'h00_A5_10_04_11_22, 5);
        send_queue(1);
        do_reset();

`ifdef UART_CMD_TIMEOUT_EN
        begin
            int n;
            send_byte(8'hA5, 1);
            tick(1'b1, 8'h10);
            n = 0;
            while (n < 200) begin
                tick(1'b0, 8'h00);
                n++;
                if (err_timeout) break;
            end
            check("timeout_cycles", 32'(n), 32'(100));
            model_reset();
            m_speed = speed;
            push_bytes(48'h0000_A5_30_00_30, 4);
            send_queue(1);
            check("timeout_next_op", 32'(cmd_op), 32'(8'h30));
            release_cmd();
        end
`endif

        // Randomised traffic with random consumer back-pressure.
        ready_en = 1;
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: build_frame(8'($urandom), int'($urandom_range(0, 16)), 1'b0);
                5:             build_frame(8'h01, 2, 1'b0);
                6:             build_frame(8'($urandom), int'($urandom_range(0, 16)), 1'b1);
                7: begin
                    tx_q.push_back(8'hA5);
                    tx_q.push_back(8'($urandom));
                    tx_q.push_back(8'($urandom_range(17, 255)));
                end
                8:             tx_q.push_back(8'($urandom_range(0, 8'hA4)));
                default:       repeat ($urandom_range(1, 8)) tick(1'b0, 8'h00);
            endcase
            send_queue(0);
        end
        ready_en = 0;
        repeat (4) tick(1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver. Consumes its one-byte-at-a-time output (valid strobe plus data byte).
- Assembles framed commands: SYNC, OP, LEN, PAYLOAD[LEN], CHK.
- Valid commands go to the core via a valid/ready handshake. The baud-rate command is handled locally: it drives the receiver's speed/set_speed inputs and is never forwarded.

Parameters:
- MAX_LEN, 16: maximum payload bytes; buffer depth.
- SYNC_BYTE, 8'hA5: frame start marker.
- SPEED_OP, 8'h01: opcode for the local baud-rate command.
- TIMEOUT_CYCLES, 20'd100000: inter-byte timeout, in clk cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- byte_valid  in  1  receiver byte strobe (the receiver's uart_inbound).
- byte_in  in  8  received byte (the receiver's data_received).
- cmd_valid  out  1  command pending.
- cmd_ready  in  1  consumer accepts the command.
- cmd_op  out  8  opcode of the pending command.
- cmd_len  out  5  payload length of the pending command.
- rd_addr  in  4  payload read index.
- rd_data  out  8  payload byte at rd_addr (combinational from the buffer).
- speed  out  13  new cycles-per-bit value, to the receiver.
- set_speed  out  1  one-cycle pulse to the receiver.
- err_chk  out  1  one-cycle pulse: checksum mismatch.
- err_len  out  1  one-cycle pulse: LEN > MAX_LEN.
- err_drop  out  1  one-cycle pulse: byte discarded while PEND.

Behaviour:
- Reset (async, active-high): all outputs 0, speed = 13'h1869, state = IDLE, checksum = 0, edge register = 0. Reset mid-frame or while PEND discards everything.
- Byte accept:
  - A byte is accepted only on a rising edge of byte_valid (byte_valid = 1 and previous-cycle byte_valid = 0).
  - A level held for several cycles counts once.
  - byte_in is sampled in the accept cycle.
- Checksum: 8-bit XOR of OP, LEN and every payload byte. SYNC is excluded.
- State machine (transitions happen on an accept unless stated):
  - IDLE: byte == SYNC_BYTE goes to OP. Any other byte is ignored, with no error.
  - OP: latch op; chk = byte; go to LEN.
  - LEN:
    - byte > MAX_LEN: pulse err_len, go to IDLE.
    - Otherwise latch len, chk ^= byte, idx = 0. Go to CHK if len == 0, else PAYLOAD.
  - PAYLOAD: buf[idx] = byte; chk ^= byte; idx++. When idx reaches len-1, go to CHK.
  - CHK:
    - byte != chk: pulse err_chk, go to IDLE.
    - Match and op == SPEED_OP and len == 2: speed = {buf[0][4:0], buf[1]}; set_speed pulses the next cycle; go to IDLE.
    - Match, any other command (including SPEED_OP with len != 2): go to PEND.
  - PEND:
    - cmd_valid = 1; cmd_op, cmd_len and the buffer are stable.
    - cmd_valid && cmd_ready: go to IDLE, cmd_valid deasserts the next cycle.
    - An accept during PEND pulses err_drop; the byte is discarded and the state is unchanged.
- Latency: cmd_valid rises on the cycle after the CHK accept. set_speed likewise rises on the cycle after the CHK accept.
- Back-to-back frames: a SYNC byte accepted in the same cycle that PEND is released is dropped (err_drop); it does not start a frame.
- rd_data is undefined outside PEND. rd_addr >= cmd_len returns stale buffer contents; no error is raised.
- The speed output holds its value until the next valid speed command or reset.

Optional Feature:
- Macro UART_CMD_TIMEOUT_EN.
- Defined:
  - A 20-bit counter clears on every accept and counts while the state is OP, LEN, PAYLOAD or CHK.
  - On reaching TIMEOUT_CYCLES: go to IDLE and pulse output err_timeout (port exists only under this macro).
  - The counter is inactive in IDLE and PEND.
- Undefined: no counter and no err_timeout port. A partial frame waits indefinitely.

Decomposition:
- Shared package/header uart_cmd_pkg holds:
  - state encoding (IDLE, OP, LEN, PAYLOAD, CHK, PEND, 3 bits);
  - SYNC_BYTE and SPEED_OP defaults;
  - UART_SPEED_DEFAULT 13'h1869, shared with the receiver.
- One sub-module: uart_cmd_buf, a MAX_LEN x 8 register file with one synchronous write port and one combinational read port.

Test Plan:
- Bytes A5 10 02 11 22 21 -> cmd_valid=1 the cycle after 21, cmd_op=10, cmd_len=2, rd_data[0]=11, rd_data[1]=22. Stays high until cmd_ready=1, low the next cycle.
- Bytes A5 01 02 01 45 47 -> set_speed pulses exactly 1 cycle, speed=13'h0145, cmd_valid stays 0. A second frame then decodes normally.
- Bytes A5 10 02 11 22 20 -> err_chk 1-cycle pulse, no cmd_valid. A following A5 30 00 30 gives cmd_valid with cmd_op=30, cmd_len=0.
- Bytes A5 10 11 -> err_len pulse, back to IDLE. Also: a held byte_valid of 5 cycles is accepted once. Also: 3C 5A before A5 are ignored with no error.
- While PEND with cmd_ready=0, send 3 bytes -> 3 err_drop pulses, cmd_op/cmd_len/buffer unchanged. Reset mid-PAYLOAD -> all outputs 0, speed=1869.
- UART_CMD_TIMEOUT_EN with TIMEOUT_CYCLES=100: A5 10 then idle -> err_timeout at 100 cycles after the 10 accept. Next A5 30 00 30 is accepted.
